// File: rtl/spi_config_receiver.sv
// SPI (mode 0, MSB first) 16-bit config frame receiver driving wave_generator controls.
// Latency: outputs/strobes SYNC_STAGES+2 clk_i after CS rise; no backpressure, host must respect 4-cycle CS-high gap.
module spi_config_receiver #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       spi_clk_i,
    input  logic       spi_mosi_i,
    input  logic       spi_cs_i,
    output logic       enable_o,
    output logic [1:0] waveform_o,
    output logic [7:0] data_o,
    output logic       set_phase_strobe_o,
    output logic       set_amplitude_strobe_o,
    output logic       frame_error_o
);

    typedef enum logic [1:0] {
        WAIT_IDLE,
        IDLE,
        SHIFT,
        COMMIT
    } state_t;

    typedef struct packed {
        logic [1:0] addr;
        logic [5:0] unused;
        logic [7:0] payload;
    } frame_t;

    localparam logic [1:0] ADDR_CTRL  = 2'b00;
    localparam logic [1:0] ADDR_PHASE = 2'b01;
    localparam logic [1:0] ADDR_AMP   = 2'b10;
    localparam logic [4:0] FRAME_BITS = 5'd16;
    localparam logic [4:0] CNT_SAT    = 5'd17;

    logic [SYNC_STAGES-1:0] cs_sync;
    logic [SYNC_STAGES-1:0] sclk_sync;
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic                   cs_hist;
    logic                   sclk_hist;
    // Fills with ones after reset; until full, the sync chains still hold reset values, not real pin samples.
    logic [SYNC_STAGES:0]   sync_primed;

    logic cs_s;
    logic sclk_s;
    logic mosi_s;
    logic cs_fall;
    logic cs_rise;
    logic sclk_rise;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cs_sync     <= '1;
            sclk_sync   <= '0;
            mosi_sync   <= '0;
            cs_hist     <= 1'b1;
            sclk_hist   <= 1'b0;
            sync_primed <= '0;
        end else begin
            cs_sync     <= {cs_sync[SYNC_STAGES-2:0], spi_cs_i};
            sclk_sync   <= {sclk_sync[SYNC_STAGES-2:0], spi_clk_i};
            mosi_sync   <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi_i};
            cs_hist     <= cs_s;
            sclk_hist   <= sclk_s;
            sync_primed <= {sync_primed[SYNC_STAGES-1:0], 1'b1};
        end
    end

    assign cs_s      = cs_sync[SYNC_STAGES-1];
    assign sclk_s    = sclk_sync[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync[SYNC_STAGES-1];
    assign cs_fall   = cs_hist & ~cs_s;
    assign cs_rise   = ~cs_hist & cs_s;
    assign sclk_rise = ~sclk_hist & sclk_s;

    state_t     state_q, state_d;
    logic [4:0] bit_cnt_q, bit_cnt_d;
    frame_t     shift_q, shift_d;
    logic       enable_q, enable_d;
    logic [1:0] waveform_q, waveform_d;
    logic [7:0] data_q, data_d;
    logic       phase_stb_q, phase_stb_d;
    logic       amp_stb_q, amp_stb_d;
    logic       err_q, err_d;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= WAIT_IDLE;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            enable_q    <= 1'b0;
            waveform_q  <= 2'b00;
            data_q      <= 8'h00;
            phase_stb_q <= 1'b0;
            amp_stb_q   <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            enable_q    <= enable_d;
            waveform_q  <= waveform_d;
            data_q      <= data_d;
            phase_stb_q <= phase_stb_d;
            amp_stb_q   <= amp_stb_d;
            err_q       <= err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        enable_d    = enable_q;
        waveform_d  = waveform_q;
        data_d      = data_q;
        phase_stb_d = 1'b0;
        amp_stb_d   = 1'b0;
        err_d       = 1'b0;

        case (state_q)
            WAIT_IDLE: begin
                // A frame already in flight at reset release must run out before we listen.
                if (sync_primed[SYNC_STAGES] && cs_s) begin
                    state_d = IDLE;
                end
            end
            IDLE: begin
                if (cs_fall) begin
                    bit_cnt_d = '0;
                    shift_d   = '0;
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                if (cs_rise) begin
                    state_d = COMMIT;
                end else if (sclk_rise) begin
                    shift_d = frame_t'({shift_q[14:0], mosi_s});
                    if (bit_cnt_q != CNT_SAT) begin
                        bit_cnt_d = bit_cnt_q + 5'd1;
                    end
                end
            end
            COMMIT: begin
                state_d = IDLE;
                if (bit_cnt_q == FRAME_BITS) begin
                    case (shift_q.addr)
                        ADDR_CTRL: begin
                            enable_d   = shift_q.payload[0];
                            waveform_d = shift_q.payload[2:1];
                        end
                        ADDR_PHASE: begin
                            data_d      = shift_q.payload;
                            phase_stb_d = 1'b1;
                        end
                        ADDR_AMP: begin
                            data_d    = shift_q.payload;
                            amp_stb_d = 1'b1;
                        end
                        default: err_d = 1'b1;
                    endcase
                end else begin
                    err_d = 1'b1;
                end
            end
            default: state_d = WAIT_IDLE;
        endcase
    end

    assign enable_o               = enable_q;
    assign waveform_o             = waveform_q;
    assign data_o                 = data_q;
    assign set_phase_strobe_o     = phase_stb_q;
    assign set_amplitude_strobe_o = amp_stb_q;
    assign frame_error_o          = err_q;

endmodule

// File: tb/tb_spi_config_receiver.sv
// Bench for spi_config_receiver: table-driven frames, reset mid-frame, and random frames against a frame-level model.
module tb_spi_config_receiver;

    localparam int SYNC_STAGES = 2;
    localparam int K_NONE = 0;
    localparam int K_PH   = 1;
    localparam int K_AMP  = 2;
    localparam int K_ERR  = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sclk = 1'b0;
    logic       mosi = 1'b0;
    logic       cs = 1'b1;
    logic       enable;
    logic [1:0] waveform;
    logic [7:0] data;
    logic       ph_stb;
    logic       amp_stb;
    logic       frame_err;

    spi_config_receiver #(.SYNC_STAGES(SYNC_STAGES)) dut (
        .clk_i                  (clk),
        .rst_i                  (rst),
        .spi_clk_i              (sclk),
        .spi_mosi_i             (mosi),
        .spi_cs_i               (cs),
        .enable_o               (enable),
        .waveform_o             (waveform),
        .data_o                 (data),
        .set_phase_strobe_o     (ph_stb),
        .set_amplitude_strobe_o (amp_stb),
        .frame_error_o          (frame_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int n_checks = 0;
    int n_errors = 0;
    int half = 40;

    typedef struct {
        int         kind;
        logic [7:0] data;
        logic       en;
        logic [1:0] wf;
        int         t;
    } evt_t;

    evt_t obs_q[$];
    evt_t exp_q[$];

    logic       m_en;
    logic [1:0] m_wf;
    logic [7:0] m_data;

    task automatic check(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    task automatic push_obs(input int k);
        evt_t e;
        e.kind = k; e.data = data; e.en = enable; e.wf = waveform; e.t = cyc;
        obs_q.push_back(e);
    endtask

    task automatic push_exp(input int k, input logic en, input logic [1:0] wf, input logic [7:0] d, input int t);
        evt_t e;
        e.kind = k; e.data = d; e.en = en; e.wf = wf; e.t = t;
        if (k != K_NONE) exp_q.push_back(e);
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (ph_stb)    push_obs(K_PH);
            if (amp_stb)   push_obs(K_AMP);
            if (frame_err) push_obs(K_ERR);
        end
    end

    task automatic cs_low();
        @(posedge clk);
        #($urandom_range(1, 9));
        cs = 1'b0;
        #(half);
    endtask

    task automatic send_bits(input logic [31:0] bits, input int hi, input int lo);
        for (int i = hi; i >= lo; i--) begin
            mosi = bits[i];
            #(half);
            sclk = 1'b1;
            #(half);
            sclk = 1'b0;
        end
    endtask

    task automatic cs_high(input int gap, output int t_rise);
        #(half);
        cs = 1'b1;
        t_rise = cyc;
        repeat (gap) @(posedge clk);
    endtask

    task automatic send_frame(input logic [31:0] bits, input int nbits, input int gap, output int t_rise);
        cs_low();
        send_bits(bits, nbits - 1, 0);
        cs_high(gap, t_rise);
    endtask

    // Frame-level reference: what a host expects a frame to do to the generator controls.
    task automatic model_frame(input logic [31:0] bits, input int nbits, input int t);
        int f, addr, payload;
        f = int'(bits[15:0]);
        addr = f / 16384;
        payload = f % 256;
        if (nbits != 16 || addr == 3) begin
            push_exp(K_ERR, m_en, m_wf, m_data, t);
        end else if (addr == 0) begin
            m_en = payload[0];
            m_wf = 2'((payload / 2) % 4);
        end else begin
            m_data = 8'(payload);
            push_exp(addr == 1 ? K_PH : K_AMP, m_en, m_wf, m_data, t);
        end
    endtask

    task automatic settle(input string tag, input logic en, input logic [1:0] wf, input logic [7:0] d);
        int n;
        repeat (12) @(posedge clk);
        @(negedge clk);
        check({tag, "_event_count"}, obs_q.size(), exp_q.size());
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            evt_t o, e;
            int lat;
            o = obs_q.pop_front();
            e = exp_q.pop_front();
            lat = o.t - e.t;
            check({tag, "_event_kind"}, o.kind, e.kind);
            check({tag, "_event_data"}, int'(o.data), int'(e.data));
            check({tag, "_event_enable"}, int'(o.en), int'(e.en));
            check({tag, "_event_waveform"}, int'(o.wf), int'(e.wf));
            n_checks++;
            if (lat < SYNC_STAGES + 1 || lat > SYNC_STAGES + 3) begin
                n_errors++;
                $display("FAIL %s_latency: got %0d cycles, expected %0d..%0d", tag, lat, SYNC_STAGES + 1, SYNC_STAGES + 3);
            end
        end
        obs_q.delete();
        exp_q.delete();
        check({tag, "_enable"}, int'(enable), int'(en));
        check({tag, "_waveform"}, int'(waveform), int'(wf));
        check({tag, "_data"}, int'(data), int'(d));
    endtask

    typedef struct {
        logic [31:0] bits;
        int          nbits;
        int          gap;
        bit          do_settle;
        int          kind;
        logic        en;
        logic [1:0]  wf;
        logic [7:0]  data;
    } vec_t;

    vec_t vecs[10];

    initial begin
        int t;
        logic [31:0] f;

        vecs[0] = '{32'h0000_0005, 16, 6, 1'b1, K_NONE, 1'b1, 2'd2, 8'h00};
        vecs[1] = '{32'h0000_40A5, 16, 6, 1'b1, K_PH,   1'b1, 2'd2, 8'hA5};
        vecs[2] = '{32'h0000_807F, 16, 4, 1'b0, K_AMP,  1'b1, 2'd2, 8'h7F};
        vecs[3] = '{32'h0000_4010, 16, 6, 1'b1, K_PH,   1'b1, 2'd2, 8'h10};
        vecs[4] = '{32'h0000_4001, 15, 6, 1'b1, K_ERR,  1'b1, 2'd2, 8'h10};
        vecs[5] = '{32'h0000_80A5, 17, 6, 1'b1, K_ERR,  1'b1, 2'd2, 8'h10};
        vecs[6] = '{32'h0000_C0FF, 16, 6, 1'b1, K_ERR,  1'b1, 2'd2, 8'h10};
        vecs[7] = '{32'h0000_00F8, 16, 6, 1'b1, K_NONE, 1'b0, 2'd0, 8'h10};
        vecs[8] = '{32'h0000_3F03, 16, 6, 1'b1, K_NONE, 1'b1, 2'd1, 8'h10};
        vecs[9] = '{32'h0000_7F42, 16, 6, 1'b1, K_PH,   1'b1, 2'd1, 8'h42};

        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        repeat (6) @(posedge clk);
        @(negedge clk);
        check("reset_enable", int'(enable), 0);
        check("reset_waveform", int'(waveform), 0);
        check("reset_data", int'(data), 0);
        check("reset_strobes", int'({ph_stb, amp_stb, frame_err}), 0);

        for (int i = 0; i < 10; i++) begin
            send_frame(vecs[i].bits, vecs[i].nbits, vecs[i].gap, t);
            push_exp(vecs[i].kind, vecs[i].en, vecs[i].wf, vecs[i].data, t);
            if (vecs[i].do_settle) settle($sformatf("vec%0d", i), vecs[i].en, vecs[i].wf, vecs[i].data);
        end

        // Reset lands after 8 bits; the rest of the frame must be dropped.
        cs_low();
        send_bits(32'h0000_40A5, 15, 8);
        @(posedge clk);
        #2 rst = 1'b1;
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        send_bits(32'h0000_40A5, 7, 0);
        cs_high(6, t);
        settle("midreset", 1'b0, 2'd0, 8'h00);

        m_en = 1'b0; m_wf = 2'd0; m_data = 8'h00;
        send_frame(32'h0000_4033, 16, 6, t);
        model_frame(32'h0000_4033, 16, t);
        settle("post_reset", m_en, m_wf, m_data);

        for (int i = 0; i < 100; i++) begin
            f = {16'h0, 2'($urandom_range(0, 2)), 14'($urandom)};
            half = 40 + 10 * $urandom_range(0, 2);
            send_frame(f, 16, $urandom_range(4, 8), t);
            model_frame(f, 16, t);
            if (i % 4 == 3) settle($sformatf("rand%0d", i), m_en, m_wf, m_data);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/spi_config_receiver.md
Name: spi_config_receiver

Overview:
Upstream control stage for wave_generator. Receives 16-bit configuration frames over a slave-only SPI link (mode 0, MSB first, CS active low) from an external host. Decodes each frame into the enable, waveform, data and set-phase/set-amplitude strobe inputs of wave_generator, replacing the direct pin-driven control. All SPI inputs are asynchronous and are synchronised into the clk_i domain.

Parameters:
SYNC_STAGES, 2, flip-flop stages in each SPI input synchroniser (min 2)

Ports:
clk_i  input  1  system clock
rst_i  input  1  asynchronous reset, active high
spi_clk_i  input  1  SPI clock from host, asynchronous; max frequency clk_i/8
spi_mosi_i  input  1  SPI data from host, asynchronous
spi_cs_i  input  1  SPI chip select from host, active low, asynchronous
enable_o  output  1  generator enable, to wave_generator enable_i
waveform_o  output  2  waveform select, to wave_generator waveform_i
data_o  output  8  phase/amplitude value, to wave_generator data_i
set_phase_strobe_o  output  1  one-cycle pulse: load data_o as phase
set_amplitude_strobe_o  output  1  one-cycle pulse: load data_o as amplitude
frame_error_o  output  1  one-cycle pulse: frame rejected

Behaviour:
- Interface: one clock, clk_i; rst_i is asynchronous and active-high.
- Reset values: enable_o=0, waveform_o=00, data_o=0x00, all strobes 0, FSM=WAIT_IDLE, bit counter=0, shift register=0, CS synchroniser=1, SCLK synchroniser=0, MOSI synchroniser=0.
- Synchronisers: SYNC_STAGES-deep chain per input, plus one history flop on sync'd SCLK and CS for edge detection. MOSI is sampled from its synchronised value in the cycle the sync'd SCLK rising edge is detected.
- Frame format, bits 15..0, MSB first: [15:14] addr, [13:8] ignored, [7:0] payload.
  - addr 00: control; payload[0] -> enable_o, payload[2:1] -> waveform_o, payload[7:3] ignored.
  - addr 01: payload -> data_o; set_phase_strobe_o pulses.
  - addr 10: payload -> data_o; set_amplitude_strobe_o pulses.
  - addr 11: reserved; rejected.
- FSM states:
  - WAIT_IDLE: entered from reset; stays until sync'd CS is high, then -> IDLE. Prevents a partial frame being accepted when reset releases mid-frame.
  - IDLE: on sync'd CS falling edge, clear counter and shift register -> SHIFT.
  - SHIFT: on each sync'd SCLK rising edge, shift sync'd MOSI into LSB. Counter increments and saturates at 17. On sync'd CS rising edge -> COMMIT; an SCLK edge detected in the same cycle is ignored.
  - COMMIT: one cycle; evaluates the frame, registers outputs -> IDLE.
- Commit rules:
  - Counter==16 and addr!=11: update per addr.
  - Counter!=16 (short or long frame) or addr==11: no output change; frame_error_o pulses.
- Strobes and frame_error_o are high for exactly one clk_i cycle: the cycle after COMMIT. data_o is valid in that same cycle and holds until the next accepted 01/10 frame.
- A control frame never changes data_o and never pulses a strobe. Phase/amplitude frames never change enable_o or waveform_o.
- Latency: outputs update SYNC_STAGES+2 clk_i cycles after the spi_cs_i rising edge, +/-1 cycle for synchroniser sampling.
- Reset mid-frame: frame is discarded, outputs return to reset values, FSM waits in WAIT_IDLE for CS high.
- Back-to-back frames: a new CS falling edge in IDLE is accepted. Minimum CS-high time is 4 clk_i cycles.

Test Plan:
- Control frame 0x0005 (addr 00, payload 0x05) -> enable_o=1, waveform_o=10, data_o stays 0x00, no strobes, frame_error_o stays 0.
- Phase frame 0x40A5 -> data_o=0xA5 with set_phase_strobe_o high for exactly 1 cycle, SYNC_STAGES+2 (+/-1) cycles after CS rise; set_amplitude_strobe_o stays 0.
- Amplitude frame 0x807F followed by phase frame 0x4010, with 4-cycle CS gap -> amplitude strobe with data_o=0x7F, then phase strobe with data_o=0x10; no errors.
- Malformed frames: 15-bit frame, 17-bit frame, and reserved 0xC0FF -> frame_error_o pulses once per frame; enable_o, waveform_o and data_o unchanged.
- rst_i asserted after 8 bits of frame 0x40A5 with CS held low, released, then frame completed -> no strobe, no output change. A following full frame 0x4033 -> data_o=0x33 with phase strobe.
- SCLK at clk_i/8 with random phase offset between clocks, 100 random valid frames -> every output matches the reference model; no missed or duplicate strobes.
